// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter stage: state encoding and the
// reset fetch address also used by the instruction-memory block.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } pc_state_e;

  localparam int unsigned PC_WIDTH_DEFAULT = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;
  logic             at_max_s;

  assign at_max_s = (count_r == {WIDTH{1'b1}});

  // count register: holds at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && !at_max_s) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule : sat_counter

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register qualified by a run/stall/halt FSM,
// combinational pc+1 for the next-PC mux, and a retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int               COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   halt_instr,
  input  logic [WIDTH-1:0]       next_pc,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       pc_plus_one,
  output logic                   running,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired
);

  pc_state_e        state_r;
  logic [WIDTH-1:0] pc_r;
  logic             running_r;
  logic             halted_r;
  logic             inc_s;
  logic             clr_s;

  // retire on every RUN edge that advances the PC or executes HALT; clear on restart
  always_comb begin
    inc_s = 1'b0;
    clr_s = 1'b0;
    if (state_r == RUN) begin
      inc_s = halt_instr | ~stall;
    end else if (state_r == HALTED) begin
      clr_s = start;
    end else begin
      inc_s = 1'b0;
      clr_s = 1'b0;
    end
  end

  // sequencer FSM, PC register and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      running_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= RUN;
            pc_r      <= RESET_PC;
            running_r <= 1'b1;
            halted_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // halt outranks stall so a HALT sitting behind a stall still retires
          if (halt_instr) begin
            state_r   <= HALTED;
            running_r <= 1'b0;
            halted_r  <= 1'b1;
          end else if (stall) begin
            state_r <= STALL;
          end else begin
            state_r <= RUN;
            pc_r    <= next_pc;
          end
        end
        STALL: begin
          if (!stall) begin
            state_r <= RUN;
          end else begin
            state_r <= STALL;
          end
        end
        HALTED: begin
          if (start) begin
            state_r   <= RUN;
            pc_r      <= RESET_PC;
            running_r <= 1'b1;
            halted_r  <= 1'b0;
          end else begin
            state_r <= HALTED;
          end
        end
        default: begin
          state_r   <= IDLE;
          pc_r      <= RESET_PC;
          running_r <= 1'b0;
          halted_r  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_s),
    .clr   (clr_s),
    .count (retired)
  );

  assign pc          = pc_r;
  assign pc_plus_one = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
  assign running     = running_r;
  assign halted      = halted_r;

endmodule : pc_sequencer

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage of the single-cycle datapath. Holds the 16-bit PC and drives pc_plus_one into the next-PC Multiplexer's input1 and pc into instruction memory. On the following edge it registers the mux result (next_pc), qualified by a small run/stall/halt state machine. Also counts retired instructions for debug and performance visibility.

Parameters:
WIDTH, 16, datapath/PC width in bits
RESET_PC, 16'h0000, PC value loaded on reset and on restart
COUNT_WIDTH, 16, width of the retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; leave IDLE/HALTED and begin fetching at RESET_PC
stall  in  1  hold PC this cycle (RUN only)
halt_instr  in  1  decoded HALT opcode at current pc
next_pc  in  WIDTH  Multiplexer result (pc_plus_one or branch target)
pc  out  WIDTH  current fetch address
pc_plus_one  out  WIDTH  pc + 1, to Multiplexer input1
running  out  1  high in RUN and STALL
halted  out  1  high in HALTED
retired  out  COUNT_WIDTH  number of instructions that advanced the PC

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, retired=0, running=0, halted=0. Release is synchronous to clk; no action on the release edge itself.
- pc_plus_one = pc + 1, combinational, modulo 2^WIDTH (16'hFFFF -> 16'h0000, no flag).
- States: IDLE, RUN, STALL, HALTED (encoding in shared package).
- IDLE: pc held. If start=1, go to RUN next edge; pc stays RESET_PC, so the first fetch is RESET_PC.
- RUN, per edge (priority order):
  1. halt_instr=1: go to HALTED, pc unchanged, retired += 1 (HALT retires).
  2. stall=1: go to STALL, pc unchanged, retired unchanged.
  3. Otherwise: pc <= next_pc, retired += 1, stay in RUN.
- STALL: pc and retired held. Leave for RUN when stall=0 at an edge, with no PC update on that edge; execution resumes the following cycle. halt_instr is ignored while in STALL.
- HALTED: pc and retired frozen. start=1 causes pc <= RESET_PC and retired <= 0 and goes to RUN. This is a restart.
- Simultaneous halt_instr and stall in RUN: halt wins.
- start is ignored in RUN and STALL.
- retired saturates at all-ones and does not wrap.
- Outputs pc, retired, and state are registered. Only pc_plus_one is combinational.
- Latency: next_pc sampled at edge N appears on pc after edge N (one cycle).
- Reset mid-operation (any state): immediate return to the reset values, independent of clk.

Decomposition:
- Shared package: state typedef/localparams (IDLE=2'd0, RUN=2'd1, STALL=2'd2, HALTED=2'd3) and a RESET_PC default constant shared with the instruction-memory block.
- One natural sub-module: sat_counter (COUNT_WIDTH, inc, clr, async rst_n) for retired.
- The rest is a single FSM plus the PC register in the top.

Test Plan:
- Reset then idle: rst_n low 20ns, start=0 for 5 cycles -> pc=16'h0000, retired=0, running=0, halted=0 throughout.
- Sequential fetch: start=1 then next_pc tied to pc_plus_one for 4 edges in RUN -> pc 0,1,2,3,4; retired=4.
- Branch: in RUN at pc=3, next_pc=16'h0040 -> pc=16'h0040 next cycle; pc_plus_one=16'h0041; retired increments by 1.
- Stall plus halt priority:
  - stall=1 for 2 cycles at pc=5 -> pc held at 5, retired unchanged, state STALL.
  - stall and halt_instr both high in RUN -> HALTED, halted=1, retired += 1.
- Wrap and saturation:
  - pc=16'hFFFF with next_pc=pc_plus_one -> pc=16'h0000.
  - retired preloaded near max (COUNT_WIDTH=4 build) -> stops at 4'hF.
- Async reset mid-run plus restart:
  - drop rst_n between edges at pc=16'h0022 -> pc=0 and state IDLE before the next edge.
  - separately, start from HALTED -> pc=RESET_PC, retired=0, RUN.
